// File: rtl/ram_responder.sv
// Memory-side responder: accepts one read/write request at a time over a
// valid/ready handshake, performs it on an internal word array, and returns
// the result over a valid/ready response channel after LATENCY cycles.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we/addr/wdata     request payload (wdata ignored for reads)
//   resp_valid/resp_ready response handshake
//   resp_we/resp_rdata    echo of the request type; read data or written word
module ram_responder #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_we,
  output logic [DATA_W-1:0] resp_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              resp_valid_d;
  logic              resp_we_d;
  logic [DATA_W-1:0] resp_rdata_d;
  logic              commit_c;

  logic [DATA_W-1:0] mem [DEPTH];

  assign req_ready = (state_q == IDLE);
  assign commit_c  = (state_q == WAIT) && (cnt_q == '0);

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid;
    resp_we_d    = resp_we;
    resp_rdata_d = resp_rdata;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Writes echo the committed word; reads see the array before this edge.
          resp_rdata_d = we_q ? wdata_q : mem[addr_q];
          resp_we_d    = we_q;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_we    <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      resp_valid <= resp_valid_d;
      resp_we    <= resp_we_d;
      resp_rdata <= resp_rdata_d;
    end
  end

  // Array write; a reset at the commit edge drops the write
  always_ff @(posedge clk) begin
    if (rst_n && commit_c && we_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule
